// File: rtl/seg_scan_display_ctrl.sv
// Multiplexed 7-segment controller: sequential BCD conversion, scan, button debounce.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_scan_display_ctrl #(
  parameter int N_DIGITS        = 4,
  parameter int DATA_W          = 14,
  parameter int REFRESH_CYCLES  = 500000,
  parameter int DEBOUNCE_CYCLES = 650000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_raw,
  output logic                btn_pulse,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [DATA_W-1:0]   load_value,
  output logic [6:0]          seg_n,
  output logic [N_DIGITS-1:0] an_n
);
  localparam int BCD_W = 4 * N_DIGITS;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(N_DIGITS) - 64'd1;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'b1000000;
      4'd1:    enc = 7'b1111001;
      4'd2:    enc = 7'b0100100;
      4'd3:    enc = 7'b0110000;
      4'd4:    enc = 7'b0011001;
      4'd5:    enc = 7'b0010010;
      4'd6:    enc = 7'b0000010;
      4'd7:    enc = 7'b1111000;
      4'd8:    enc = 7'b0000000;
      4'd9:    enc = 7'b0010000;
      default: enc = 7'b1111111;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   bin_q;
  logic [BCD_W-1:0]    bcd_q, bcd_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_cap_q, ovf_q;
  logic [BCD_W-1:0]    disp_q;
  logic                ready_q;

  logic [REF_W-1:0]    ref_q;
  logic [IDX_W-1:0]    idx_q;
  logic [6:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] an_q, an_d;

  logic [1:0]          sync_q;
  logic                db_q, pulse_q;
  logic [DEB_W-1:0]    deb_cnt_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (load_valid && ready_q) state_d = SHIFT;
      SHIFT:   if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD digit >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++)
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
      disp_q    <= '0;
      ready_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: if (load_valid && ready_q) begin
          bin_q     <= load_value;
          bcd_q     <= '0;
          cnt_q     <= '0;
          ovf_cap_q <= 64'(load_value) > MAX_VAL;
          ready_q   <= 1'b0;
        end
        SHIFT: begin
          bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        COMMIT: begin
          disp_q  <= bcd_q;
          ovf_q   <= ovf_cap_q;
          ready_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEG_LZB_EN
  logic lead_zero;
  always_comb begin
    lead_zero = (idx_q != '0);
    for (int k = 1; k < N_DIGITS; k++)
      if (k >= int'(idx_q) && disp_q[4*k +: 4] != 4'd0) lead_zero = 1'b0;
  end
`endif

  always_comb begin
    seg_d = enc(disp_q[4*idx_q +: 4]);
`ifdef SEG_LZB_EN
    if (lead_zero) seg_d = 7'b1111111;
`endif
    if (ovf_q) seg_d = 7'b0111111;
  end

  assign an_d = ~(N_DIGITS'(1) << idx_q);

  // seg and anode registered together so they switch on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= '0;
      seg_q <= '1;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (ref_q == REF_W'(REFRESH_CYCLES - 1)) begin
        ref_q <= '0;
        idx_q <= (idx_q == '0) ? IDX_W'(N_DIGITS - 1) : idx_q - IDX_W'(1);
      end else begin
        ref_q <= ref_q + REF_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= '0;
      db_q      <= 1'b0;
      deb_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      pulse_q <= 1'b0;
      if (sync_q[1] == db_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_q      <= sync_q[1];
        deb_cnt_q <= '0;
        pulse_q   <= sync_q[1];
      end else begin
        deb_cnt_q <= deb_cnt_q + DEB_W'(1);
      end
    end
  end

  assign btn_pulse  = pulse_q;
  assign load_ready = ready_q;
  assign seg_n      = seg_q;
  assign an_n       = an_q;
endmodule
